find_global_bkt: RTL and testbench

- Backtrack-level search stage that runs when the bin-manager controller enters FIND_BKT_LVL after a local UNSAT from the core.
- Scans the global per-level decision table downward from the level supplied by the core. Finds the highest level whose decision is valid and not yet flipped, marks it flipped, and returns that level and its owning bin.
- Returns bin 0 when no such level exists. The controller treats bin 0 as global UNSAT.

---
 rtl/find_global_bkt.sv | 144 ++++++++++++++
 tb/tb_find_global_bkt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/find_global_bkt.sv
// Backtrack-level search: scans the global decision table downward for the highest valid, unflipped level and flips it.
// Optional scan counter on scan_cnt_o is built when FIND_BKT_SCAN_CNT_EN is defined.
module find_global_bkt #(
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_ENTRY  = WIDTH_BIN_ID + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_find_i,
    input  logic [WIDTH_LVL-1:0]    start_lvl_i,
    output logic                    done_find_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    output logic                    busy_o,
    output logic                    lvl_rd_en_o,
    output logic [WIDTH_LVL-1:0]    lvl_rd_addr_o,
    input  logic [WIDTH_ENTRY-1:0]  lvl_rd_data_i,
    output logic                    lvl_wr_en_o,
    output logic [WIDTH_LVL-1:0]    lvl_wr_addr_o,
    output logic [WIDTH_ENTRY-1:0]  lvl_wr_data_o,
    output logic [WIDTH_LVL-1:0]    scan_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WB,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH_LVL-1:0]    lvl_q, lvl_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;

    logic                    entry_valid;
    logic                    entry_flipped;
    logic [WIDTH_BIN_ID-1:0] entry_bin;
    logic                    entry_hit;
    logic                    start_accept;

    assign entry_valid   = lvl_rd_data_i[WIDTH_BIN_ID+1];
    assign entry_flipped = lvl_rd_data_i[WIDTH_BIN_ID];
    assign entry_bin     = lvl_rd_data_i[WIDTH_BIN_ID-1:0];
    // Bin 0 means "no owner", so such an entry can never be a backtrack target.
    assign entry_hit     = entry_valid && !entry_flipped && (entry_bin != '0);
    assign start_accept  = (state_q == S_IDLE) && start_find_i;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        bkt_lvl_d = bkt_lvl_q;
        bkt_bin_d = bkt_bin_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_find_i) begin
                    bkt_lvl_d = '0;
                    bkt_bin_d = '0;
                    if (start_lvl_i != '0) begin
                        lvl_d   = start_lvl_i;
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD:  state_d = S_CHK;
            S_CHK: begin
                if (entry_hit) begin
                    bkt_lvl_d = lvl_q;
                    bkt_bin_d = entry_bin;
                    state_d   = S_WB;
                end else if (lvl_q == WIDTH_LVL'(1)) begin
                    bkt_lvl_d = '0;
                    bkt_bin_d = '0;
                    state_d   = S_DONE;
                end else begin
                    lvl_d   = lvl_q - WIDTH_LVL'(1);
                    state_d = S_RD;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lvl_q     <= '0;
            bkt_lvl_q <= '0;
            bkt_bin_q <= '0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            bkt_lvl_q <= bkt_lvl_d;
            bkt_bin_q <= bkt_bin_d;
        end
    end

    // Strobes and addresses decode straight from the state so they are zero outside RD/WB.
    assign busy_o        = (state_q != S_IDLE);
    assign done_find_o   = (state_q == S_DONE);
    assign lvl_rd_en_o   = (state_q == S_RD);
    assign lvl_rd_addr_o = lvl_rd_en_o ? lvl_q : '0;
    assign lvl_wr_en_o   = (state_q == S_WB);
    assign lvl_wr_addr_o = lvl_wr_en_o ? bkt_lvl_q : '0;
    assign lvl_wr_data_o = lvl_wr_en_o ? {2'b11, bkt_bin_q} : '0;
    assign bkt_lvl_o     = bkt_lvl_q;
    assign bkt_bin_o     = bkt_bin_q;

`ifdef FIND_BKT_SCAN_CNT_EN
    logic [WIDTH_LVL-1:0] scan_q, scan_d;

    always_comb begin
        scan_d = scan_q;
        if (start_accept) begin
            scan_d = '0;
        end else if ((state_q == S_CHK) && (scan_q != '1)) begin
            scan_d = scan_q + WIDTH_LVL'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_d;
        end
    end

    assign scan_cnt_o = scan_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign scan_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_find_global_bkt.sv
// Self-checking bench for find_global_bkt: table memory model, directed cases, then randomized searches vs. a reference model.
module tb_find_global_bkt;

    localparam int WL    = 16;
    localparam int WB    = 10;
    localparam int WE    = WB + 2;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_find_i;
    logic [WL-1:0] start_lvl_i;
    logic          done_find_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [WB-1:0] bkt_bin_o;
    logic          busy_o;
    logic          lvl_rd_en_o;
    logic [WL-1:0] lvl_rd_addr_o;
    logic [WE-1:0] lvl_rd_data_i;
    logic          lvl_wr_en_o;
    logic [WL-1:0] lvl_wr_addr_o;
    logic [WE-1:0] lvl_wr_data_o;
    logic [WL-1:0] scan_cnt_o;

    always #5 clk = ~clk;

    find_global_bkt dut (
        .clk          (clk),
        .rst          (rst),
        .start_find_i (start_find_i),
        .start_lvl_i  (start_lvl_i),
        .done_find_o  (done_find_o),
        .bkt_lvl_o    (bkt_lvl_o),
        .bkt_bin_o    (bkt_bin_o),
        .busy_o       (busy_o),
        .lvl_rd_en_o  (lvl_rd_en_o),
        .lvl_rd_addr_o(lvl_rd_addr_o),
        .lvl_rd_data_i(lvl_rd_data_i),
        .lvl_wr_en_o  (lvl_wr_en_o),
        .lvl_wr_addr_o(lvl_wr_addr_o),
        .lvl_wr_data_o(lvl_wr_data_o),
        .scan_cnt_o   (scan_cnt_o)
    );

    // Table memory: one-cycle read latency, bench-side load port, logs of DUT accesses.
    logic [WE-1:0] mem [DEPTH];
    logic          load_en;
    logic [5:0]    load_addr;
    logic [WE-1:0] load_data;
    int            rd_log[$];
    int            wr_addr_log[$];
    int            wr_data_log[$];

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (lvl_rd_en_o) begin
            lvl_rd_data_i <= mem[lvl_rd_addr_o[5:0]];
            rd_log.push_back(int'(lvl_rd_addr_o));
        end
        if (lvl_wr_en_o) begin
            mem[lvl_wr_addr_o[5:0]] <= lvl_wr_data_o;
            wr_addr_log.push_back(int'(lvl_wr_addr_o));
            wr_data_log.push_back(int'(lvl_wr_data_o));
        end
    end

    logic [WE-1:0] ref_tbl [DEPTH];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int a, input bit v, input bit f, input int bin);
        logic [WE-1:0] e;
        e         = {v, f, WB'(bin)};
        load_en   = 1'b1;
        load_addr = a[5:0];
        load_data = e;
        @(negedge clk);
        load_en    = 1'b0;
        ref_tbl[a] = e;
    endtask

    // Reference: walk levels s..1, take the first valid/unflipped/non-zero-bin entry and flip it.
    function automatic void model(input int s, output int lvl, output int bin, output int k);
        bit found;
        found = 1'b0;
        lvl   = 0;
        bin   = 0;
        k     = 0;
        for (int l = s; l >= 1 && !found; l--) begin
            k++;
            if (ref_tbl[l][WE-1] && !ref_tbl[l][WE-2] && ref_tbl[l][WB-1:0] != '0) begin
                found          = 1'b1;
                lvl            = l;
                bin            = int'(ref_tbl[l][WB-1:0]);
                ref_tbl[l][WE-2] = 1'b1;
            end
        end
    endfunction

    function automatic int exp_scan(input int k);
`ifdef FIND_BKT_SCAN_CNT_EN
        return k;
`else
        return 0 * k;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".done"},  32'(done_find_o), 0);
        check({tag, ".busy"},  32'(busy_o), 0);
        check({tag, ".lvl"},   32'(bkt_lvl_o), 0);
        check({tag, ".bin"},   32'(bkt_bin_o), 0);
        check({tag, ".rd_en"}, 32'(lvl_rd_en_o), 0);
        check({tag, ".rd_ad"}, 32'(lvl_rd_addr_o), 0);
        check({tag, ".wr_en"}, 32'(lvl_wr_en_o), 0);
        check({tag, ".wr_ad"}, 32'(lvl_wr_addr_o), 0);
        check({tag, ".wr_dt"}, 32'(lvl_wr_data_o), 0);
        check({tag, ".scan"},  32'(scan_cnt_o), 0);
    endtask

    task automatic run_search(input int s, input bit pulse_again, input string tag);
        int el, eb, ek, exp_lat, rd0, wr0, edges;
        model(s, el, eb, ek);
        exp_lat = (el != 0) ? 2 * ek + 2 : 2 * ek + 1;
        rd0 = rd_log.size();
        wr0 = wr_addr_log.size();
        start_find_i = 1'b1;
        start_lvl_i  = WL'(s);
        @(negedge clk);
        start_find_i = 1'b0;
        start_lvl_i  = '0;
        edges = 1;
        while (!done_find_o && edges < 400) begin
            if (pulse_again && edges == 2) begin
                start_find_i = 1'b1;
                start_lvl_i  = WL'(DEPTH - 1);
            end
            @(negedge clk);
            start_find_i = 1'b0;
            start_lvl_i  = '0;
            edges++;
        end
        check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
        check({tag, ".done"},    32'(done_find_o), 1);
        check({tag, ".busy"},    32'(busy_o), 1);
        check({tag, ".lvl"},     32'(bkt_lvl_o), 32'(el));
        check({tag, ".bin"},     32'(bkt_bin_o), 32'(eb));
        check({tag, ".scan"},    32'(scan_cnt_o), 32'(exp_scan(ek)));
        check({tag, ".nreads"},  32'(rd_log.size() - rd0), 32'(ek));
        for (int i = 0; i < ek && rd0 + i < rd_log.size(); i++)
            check({tag, ".rd_addr"}, 32'(rd_log[rd0+i]), 32'(s - i));
        check({tag, ".nwrites"}, 32'(wr_addr_log.size() - wr0), (el != 0) ? 1 : 0);
        if (el != 0 && wr_addr_log.size() > wr0) begin
            check({tag, ".wr_addr"}, 32'(wr_addr_log[wr0]), 32'(el));
            check({tag, ".wr_data"}, 32'(wr_data_log[wr0]), 32'({2'b11, WB'(eb)}));
        end
        @(negedge clk);
        check({tag, ".done_low"}, 32'(done_find_o), 0);
        check({tag, ".idle"},     32'(busy_o), 0);
        check({tag, ".lvl_hold"}, 32'(bkt_lvl_o), 32'(el));
        check({tag, ".bin_hold"}, 32'(bkt_bin_o), 32'(eb));
        check({tag, ".scan_hold"}, 32'(scan_cnt_o), 32'(exp_scan(ek)));
    endtask

    task automatic table_check(input string tag);
        int mism;
        mism = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] !== ref_tbl[a]) mism++;
        check({tag, ".table"}, 32'(mism), 0);
    endtask

    initial begin
        int wr0;
        rst          = 1'b0;
        start_find_i = 1'b0;
        start_lvl_i  = '0;
        load_en      = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        for (int a = 0; a < DEPTH; a++) set_entry(a, 1'b0, 1'b0, 0);

        // Direct hit at the start level.
        set_entry(5, 1'b1, 1'b0, 7);
        run_search(5, 1'b0, "hit5");
        // Two flipped levels, hit at 4; a second start during busy must be ignored.
        set_entry(6, 1'b1, 1'b1, 2);
        set_entry(4, 1'b1, 1'b0, 3);
        run_search(6, 1'b1, "hit4");
        // Exhausted: 3 flipped, 2 and 1 invalid.
        set_entry(3, 1'b1, 1'b1, 1);
        set_entry(2, 1'b0, 1'b0, 5);
        set_entry(1, 1'b0, 1'b0, 0);
        run_search(3, 1'b0, "exhaust");
        run_search(0, 1'b0, "zero");
        // Valid entry owned by bin 0 is a miss.
        set_entry(2, 1'b1, 1'b0, 0);
        set_entry(1, 1'b1, 1'b0, 4);
        run_search(2, 1'b0, "bin0");
        table_check("directed");

        // Reset while in CHK of a hit: no write-back, everything returns to zero.
        set_entry(5, 1'b1, 1'b0, 9);
        start_find_i = 1'b1;
        start_lvl_i  = WL'(5);
        @(negedge clk);
        start_find_i = 1'b0;
        start_lvl_i  = '0;
        @(negedge clk);
        wr0 = wr_addr_log.size();
        rst = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort.nwrites", 32'(wr_addr_log.size() - wr0), 0);
        table_check("abort");
        run_search(5, 1'b0, "after_abort");

        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < DEPTH; a++)
                set_entry(a, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30, $urandom_range(0, 3));
            for (int n = 0; n < 8; n++)
                run_search($urandom_range(0, DEPTH - 1), $urandom_range(0, 1) == 1, $sformatf("rnd%0d_%0d", r, n));
            table_check($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
